// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Bundles the request side and the data-memory side of the memory access unit.
//   Request side : start, is_store, ls_size, load_signed, addr_in, wdata_in (to unit)
//                  busy, done, align_exc, load_data (from unit)
//   Memory side  : mem_addr, mem_wr, mem_wdata (from unit), mem_rdata (to unit)
// Modports: slave = the memory access unit, master = the requester / memory model.
interface mem_access_unit_if;
    logic        start;
    logic        is_store;
    logic [1:0]  ls_size;
    logic        load_signed;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        busy;
    logic        done;
    logic        align_exc;
    logic [31:0] load_data;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  start, is_store, ls_size, load_signed, addr_in, wdata_in, mem_rdata,
        output busy, done, align_exc, load_data, mem_addr, mem_wr, mem_wdata
    );

    modport master (
        output start, is_store, ls_size, load_signed, addr_in, wdata_in, mem_rdata,
        input  busy, done, align_exc, load_data, mem_addr, mem_wr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Multicycle load/store sequencer for a single-port data memory. Performs
// word/half/byte loads with sign or zero extension, word stores directly and
// half/byte stores as read-modify-write. Misaligned requests raise align_exc
// and never touch memory.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : mem_access_unit_if.slave (request strobe/attributes, status
//              pulses, load result, memory address/write/data bus)
// Parameter MEM_LATENCY : cycles from mem_addr stable to mem_rdata valid (>=1).
module mem_access_unit #(
    parameter int MEM_LATENCY = 1
) (
    input logic               clk,
    input logic               reset_n,
    mem_access_unit_if.slave  bus
);

    localparam int CW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, RWAIT, WRITE, DONE, EXC} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]    addr_low_q;
    logic [1:0]    size_q;
    logic          signed_q;
    logic          store_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [31:0]   load_data_q;
    logic          aligned;
    logic          word_req;

    // Reserved size 11 behaves as a word access.
    function automatic logic is_word(input logic [1:0] size);
        return (size == 2'b00) || (size == 2'b11);
    endfunction

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] size,
                                            input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[8*off +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b01:   r = {{16{sgn & h[15]}}, h};
            2'b10:   r = {{24{sgn & b[7]}}, b};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the read word with the new store data.
    function automatic logic [31:0] merge(input logic [31:0] rdata, input logic [31:0] wdata,
                                          input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = rdata;
        case (size)
            2'b01: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            2'b10:   r[8*off +: 8] = wdata[7:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

    always_comb begin
        aligned  = 1'b1;
        word_req = is_word(bus.ls_size);
        if (word_req)
            aligned = (bus.addr_in[1:0] == 2'b00);
        else if (bus.ls_size == 2'b01)
            aligned = ~bus.addr_in[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; status outputs are decoded straight from the state so
    // that an asynchronous reset removes mem_wr/done/align_exc immediately.
    always_comb begin
        state_d       = state_q;
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == DONE);
        bus.align_exc = (state_q == EXC);
        bus.mem_wr    = (state_q == WRITE);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (!aligned)                    state_d = EXC;
                    else if (bus.is_store && word_req) state_d = WRITE;
                    else                             state_d = RWAIT;
                end
            end
            RWAIT: begin
                if (cnt_q == '0) state_d = store_q ? WRITE : DONE;
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            EXC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, read-wait counter, read capture and write-data preparation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            addr_low_q  <= 2'b00;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            store_q     <= 1'b0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            load_data_q <= '0;
        end else begin
            if (state_q == IDLE && bus.start && aligned) begin
                addr_low_q <= bus.addr_in[1:0];
                size_q     <= bus.ls_size;
                signed_q   <= bus.load_signed;
                store_q    <= bus.is_store;
                wdata_q    <= bus.wdata_in;
                mem_addr_q <= {bus.addr_in[31:2], 2'b00};
                cnt_q      <= CW'(MEM_LATENCY);
                if (bus.is_store && word_req)
                    mem_wdata_q <= bus.wdata_in;
            end
            if (state_q == RWAIT) begin
                if (cnt_q != '0)
                    cnt_q <= cnt_q - CW'(1);
                else if (store_q)
                    mem_wdata_q <= merge(bus.mem_rdata, wdata_q, size_q, addr_low_q);
                else
                    load_data_q <= extract(bus.mem_rdata, size_q, addr_low_q, signed_q);
            end
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.load_data = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit (MEM_LATENCY = 1).
// Memory is modelled as a constant read word per request; writes are
// recorded by a monitor sampling on the falling edge.
module tb_mem_access_unit;

    logic clk;
    logic reset_n;
    int   tests_run;
    int   fail_count;
    int   wr_count;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] exp_ld;
    int   cycles;
    logic exc;

    mem_access_unit_if bus ();

    mem_access_unit #(.MEM_LATENCY(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write cycle seen on the bus.
    always @(negedge clk) begin
        if (bus.mem_wr === 1'b1) begin
            wr_count = wr_count + 1;
            wr_addr  = bus.mem_addr;
            wr_data  = bus.mem_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run = tests_run + 1;
        assert (observed === expected) else begin
            fail_count = fail_count + 1;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issue one request and wait (bounded) for done or align_exc.
    // cycles = index n such that the pulse is high in the cycle after edge En.
    task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                 output int n, output logic ex);
        @(negedge clk);
        wr_count        = 0;
        bus.mem_rdata   = rd;
        bus.is_store    = st;
        bus.ls_size     = sz;
        bus.load_signed = sg;
        bus.addr_in     = a;
        bus.wdata_in    = wd;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!(bus.done === 1'b1 || bus.align_exc === 1'b1) && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        ex = bus.align_exc;
    endtask

    // The cycle after a done/align_exc pulse must be idle with no pulse.
    task automatic checkIdleNext(input string tag);
        @(negedge clk);
        checkOutput({tag, "_busy_after"}, {31'b0, bus.busy}, 32'd0);
        checkOutput({tag, "_done_after"}, {31'b0, bus.done}, 32'd0);
    endtask

    initial begin
        tests_run   = 0;
        fail_count  = 0;
        wr_count    = 0;
        wr_addr     = '0;
        wr_data     = '0;
        exp_ld      = 32'h0;
        reset_n     = 1'b0;
        bus.start       = 1'b0;
        bus.is_store    = 1'b0;
        bus.ls_size     = 2'b00;
        bus.load_signed = 1'b0;
        bus.addr_in     = '0;
        bus.wdata_in    = '0;
        bus.mem_rdata   = '0;

        #3;
        checkOutput("rst_busy",      {31'b0, bus.busy},      32'd0);
        checkOutput("rst_done",      {31'b0, bus.done},      32'd0);
        checkOutput("rst_align_exc", {31'b0, bus.align_exc}, 32'd0);
        checkOutput("rst_mem_wr",    {31'b0, bus.mem_wr},    32'd0);
        checkOutput("rst_mem_addr",  bus.mem_addr,  32'h0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
        checkOutput("rst_load_data", bus.load_data, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Word load
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, cycles, exc);
        exp_ld = 32'hDEAD_BEEF;
        checkOutput("wl_cycle",     cycles, 32'd2);
        checkOutput("wl_align_exc", {31'b0, bus.align_exc}, 32'd0);
        checkOutput("wl_mem_addr",  bus.mem_addr, 32'h0000_0010);
        checkOutput("wl_load_data", bus.load_data, exp_ld);
        checkOutput("wl_wr_count",  wr_count, 32'd0);
        checkIdleNext("wl");

        // Byte load, signed and unsigned, top lane
        applyStimulus(1'b0, 2'b10, 1'b1, 32'h0000_0013, 32'h0, 32'h80FF_0000, cycles, exc);
        checkOutput("bls_cycle", cycles, 32'd2);
        checkOutput("bls_data",  bus.load_data, 32'hFFFF_FF80);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0, 32'h80FF_0000, cycles, exc);
        exp_ld = 32'h0000_0080;
        checkOutput("blu_data",  bus.load_data, exp_ld);
        checkOutput("blu_mem_addr", bus.mem_addr, 32'h0000_0010);

        // Half load signed, upper half
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, 32'h80FF_0000, cycles, exc);
        exp_ld = 32'hFFFF_80FF;
        checkOutput("hls_data", bus.load_data, exp_ld);

        // Reserved size acts as word load
        applyStimulus(1'b0, 2'b11, 1'b1, 32'h0000_0004, 32'h0, 32'h8765_4321, cycles, exc);
        exp_ld = 32'h8765_4321;
        checkOutput("rsv_data", bus.load_data, exp_ld);

        // Half store read-modify-write
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h1234_ABCD, 32'h1111_2222, cycles, exc);
        checkOutput("hs_cycle",     cycles, 32'd3);
        checkOutput("hs_wr_count",  wr_count, 32'd1);
        checkOutput("hs_wr_data",   wr_data, 32'hABCD_2222);
        checkOutput("hs_wr_addr",   wr_addr, 32'h0000_0020);
        checkOutput("hs_load_data", bus.load_data, exp_ld);

        // Byte store into lane 1
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'hFFFF_FF55, 32'h1122_3344, cycles, exc);
        checkOutput("bs_cycle",    cycles, 32'd3);
        checkOutput("bs_wr_count", wr_count, 32'd1);
        checkOutput("bs_wr_data",  wr_data, 32'h1122_5544);
        checkOutput("bs_wr_addr",  wr_addr, 32'h0000_0100);

        // Word store
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, cycles, exc);
        checkOutput("ws_cycle",     cycles, 32'd1);
        checkOutput("ws_wr_count",  wr_count, 32'd1);
        checkOutput("ws_wr_data",   wr_data, 32'hCAFE_F00D);
        checkOutput("ws_wr_addr",   wr_addr, 32'h0000_0040);
        checkOutput("ws_load_data", bus.load_data, exp_ld);
        checkIdleNext("ws");

        // Misaligned word load
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0, 32'h0, cycles, exc);
        checkOutput("mwl_cycle", cycles, 32'd0);
        checkOutput("mwl_exc",   {31'b0, exc}, 32'd1);
        checkOutput("mwl_done",  {31'b0, bus.done}, 32'd0);
        checkIdleNext("mwl");
        checkOutput("mwl_wr_count", wr_count, 32'd0);

        // Misaligned half store
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0005, 32'h1234_5678, 32'h0, cycles, exc);
        checkOutput("mhs_cycle", cycles, 32'd0);
        checkOutput("mhs_exc",   {31'b0, exc}, 32'd1);
        checkOutput("mhs_done",  {31'b0, bus.done}, 32'd0);
        checkIdleNext("mhs");
        checkOutput("mhs_wr_count", wr_count, 32'd0);
        checkOutput("mhs_load_data", bus.load_data, exp_ld);

        // Reset during RWAIT of a byte store
        @(negedge clk);
        wr_count        = 0;
        bus.mem_rdata   = 32'hAAAA_AAAA;
        bus.is_store    = 1'b1;
        bus.ls_size     = 2'b10;
        bus.addr_in     = 32'h0000_0031;
        bus.wdata_in    = 32'h0000_0077;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("rw_busy_before", {31'b0, bus.busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rw_busy",      {31'b0, bus.busy},   32'd0);
        checkOutput("rw_mem_wr",    {31'b0, bus.mem_wr}, 32'd0);
        checkOutput("rw_mem_addr",  bus.mem_addr,  32'h0);
        checkOutput("rw_load_data", bus.load_data, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("rw_done",     {31'b0, bus.done}, 32'd0);
        checkOutput("rw_wr_count", wr_count, 32'd0);
        reset_n = 1'b1;

        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0008, 32'h0, 32'h0BAD_F00D, cycles, exc);
        checkOutput("rl_cycle",     cycles, 32'd2);
        checkOutput("rl_load_data", bus.load_data, 32'h0BAD_F00D);
        checkOutput("rl_wr_count",  wr_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle memory sequencer that sits directly downstream of the memory address mux. It accepts the selected byte address plus a load/store request, drives the single-port data memory, and performs word/half/byte loads with extension. Partial stores are done as read-modify-write. Misaligned requests are flagged as an exception and never reach memory.

## Interface
Parameters:
- MEM_LATENCY, 1, cycles from mem_addr stable to mem_rdata valid (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request strobe; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- ls_size  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- load_signed  in  1  1 = sign-extend half/byte loads, 0 = zero-extend
- addr_in  in  32  byte address from address mux
- wdata_in  in  32  store data (low bits used for half/byte)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- align_exc  out  1  one-cycle misalignment pulse (instead of done)
- load_data  out  32  extended load result, held until next load completes
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wr  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

## Operation
- Byte lanes little-endian: byte k = bits [8k+7:8k]; half h = bits [16h+15:16h].
- On start in IDLE, latch addr_in, wdata_in, is_store, ls_size, load_signed. Inputs are ignored while busy.
- Alignment: word needs addr[1:0]=00; half needs addr[0]=0; byte is always aligned. If misaligned, go to EXC. Memory is not touched.
- States: IDLE, RWAIT, WRITE, DONE, EXC.
  - IDLE → EXC on misaligned request.
  - IDLE → WRITE on word store.
  - IDLE → RWAIT on load or half/byte store.
  - RWAIT lasts MEM_LATENCY+1 cycles (down-counter). On its last edge, mem_rdata is captured. Then → DONE for loads, → WRITE for partial stores.
  - WRITE: mem_wr=1 for exactly one cycle → DONE.
  - DONE: done=1 → IDLE. EXC: align_exc=1 → IDLE.
- Partial store merge: captured word with the selected lane replaced by wdata[15:0] (half) or wdata[7:0] (byte). Other lanes are unchanged.
- Word store: mem_wdata = latched wdata.
- Load extract: select the lane by addr[1:0]/addr[1], then extend to 32 bits per load_signed. Word loads pass through. load_data updates only on load completion; stores do not modify it.
- mem_addr is held constant from the request edge through DONE. mem_wdata is don't-care when mem_wr=0.

## Timing
- Reset values (asynchronous, immediate): state IDLE, busy 0, done 0, align_exc 0, mem_wr 0, mem_addr 0, mem_wdata 0, load_data 0, counter 0.
- Edge E0 samples start. Relative to E0, done is high in the cycle after edge:
  - word store: E1 (mem_wr high E0–E1)
  - load: E(MEM_LATENCY+1)
  - half/byte store: E(MEM_LATENCY+2)
  - misaligned: align_exc high after E0
- busy rises after E0 and falls after the done/align_exc cycle. The earliest next accepted start is the edge that ends that cycle's successor, i.e. start must be sampled in IDLE.
- start held high continuously starts a new request on every IDLE cycle. There is no back-to-back acceptance in DONE.
- Reset mid-transaction aborts immediately: mem_wr drops with reset_n low, no write completes, and done/align_exc are not issued.
- Only one of done and align_exc is ever high in a cycle.

## Test plan
- Word load, MEM_LATENCY=1, addr 0x0000_0010, mem returns 0xDEADBEEF → done after E2, load_data=0xDEADBEEF, mem_wr never high.
- Byte load signed, addr 0x13, mem 0x80FF_0000 → load_data=0xFFFF_FF80. Unsigned → 0x0000_0080.
- Half store, addr 0x22, wdata 0x1234_ABCD, mem 0x1111_2222 → one write of 0xABCD_2222 to mem_addr 0x20, done after E3.
- Word store, addr 0x40, wdata 0xCAFEF00D → mem_wr high E0–E1 only, mem_wdata 0xCAFEF00D, done after E1, load_data unchanged.
- Misaligned word load at 0x06 and half store at 0x05 → align_exc pulse after E0, no mem_wr, done stays 0, busy back to 0 next cycle.
- reset_n low during RWAIT of a byte store → mem_wr never asserts, all outputs at reset values; a new word load issued after release completes normally.
